// File: rtl/mem_access_if.sv
// -----------------------------------------------------------------------------
// mem_access_if
//   Data-memory request/acknowledge bus between the memory-access stage
//   (master) and the data memory (slave).
//
//   Handshake: the master raises DMemReq and holds DMemAddr, DMemWData,
//   DMemByteEn and DMemWE stable until it samples DMemAck=1 on a rising clock
//   edge. That edge completes the transfer. DMemAck is ignored while DMemReq
//   is low. For reads, DMemRData must be valid in the cycle DMemAck is high.
//
//   Bit numbering: the bus is big-endian. Byte lane k (k = addr[1:0]) occupies
//   data bits [31-8k -: 8], so lane 0 is the most significant byte.
//   DMemByteEn[3] enables lane 0 and DMemByteEn[0] enables lane 3.
//
//   Signals:
//     DMemAddr   [31:0]  word-aligned address (bits 1:0 always 0)
//     DMemWData  [31:0]  store data, replicated across lanes
//     DMemByteEn [3:0]   lane enables
//     DMemReq            request strobe
//     DMemWE             write strobe (only with DMemReq)
//     DMemAck            transfer complete
//     DMemRData  [31:0]  read data
// -----------------------------------------------------------------------------
interface mem_access_if;
    logic [31:0] DMemAddr;
    logic [31:0] DMemWData;
    logic [3:0]  DMemByteEn;
    logic        DMemReq;
    logic        DMemWE;
    logic        DMemAck;
    logic [31:0] DMemRData;

    modport master (
        output DMemAddr, DMemWData, DMemByteEn, DMemReq, DMemWE,
        input  DMemAck, DMemRData
    );

    modport slave (
        input  DMemAddr, DMemWData, DMemByteEn, DMemReq, DMemWE,
        output DMemAck, DMemRData
    );
endinterface

// File: rtl/mem_access.sv
// -----------------------------------------------------------------------------
// mem_access
//   Memory-access pipeline stage. Registers the execute-stage results, runs a
//   load or store over the data-memory handshake, aligns and extends load data
//   and presents the result to write-back. While an access is outstanding it
//   freezes upstream (MemStall) and withholds the register write.
//
//   Bit numbering: vectors are declared [N-1:0]. The big-endian bit k of the
//   architectural [0:N-1] numbering is bit [N-1-k] here, so the "addr[30:31]"
//   lane select is addr[1:0] and the "addr[30]" half select is addr[1].
//
//   Ports:
//     clk, reset         clock, asynchronous active-low reset
//     stall              no valid upstream instruction: capture a bubble
//     Next*              execute-stage results to capture
//     dmem               data-memory bus (master side)
//     MEMDout..RegWAddr  registered instruction fields to write-back
//     MemStall           freeze all upstream stages
//     MisalignedExc      misaligned access in the stage (trap build only)
//     dbg_state          FSM state, 1 = ACCESS
//
//   Build option:
//     MEM_MISALIGN_TRAP_EN  misaligned LH/LHU/SH/LW/SW do not access memory,
//                           suppress their register write and raise
//                           MisalignedExc. Undefined: low address bits that
//                           do not fit the access size are ignored.
// -----------------------------------------------------------------------------
module mem_access (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic [31:0] NextALUOut,
    input  logic [31:0] NextFPUOut,
    input  logic [31:0] NextStoreData,
    input  logic [5:0]  NextOpcode,
    input  logic [5:0]  NextFunct,
    input  logic [31:0] NextPCPlusFour,
    input  logic [15:0] NextImmediate,
    input  logic [1:0]  NextDInSrc,
    input  logic        NextRegWE,
    input  logic [5:0]  NextRegWAddr,
    input  logic        NextMemRE,
    input  logic        NextMemWE,
    mem_access_if.master dmem,
    output logic [31:0] MEMDout,
    output logic [31:0] ALUOut,
    output logic [31:0] FPUOut,
    output logic [31:0] PCPlusFour,
    output logic [5:0]  Opcode,
    output logic [5:0]  Funct,
    output logic [15:0] Immediate,
    output logic [1:0]  DInSrc,
    output logic        RegWE,
    output logic [5:0]  RegWAddr,
    output logic        MemStall,
    output logic        MisalignedExc,
    output logic        dbg_state
);

    localparam logic [5:0] OP_LB     = 6'h20;
    localparam logic [5:0] OP_LH     = 6'h21;
    localparam logic [5:0] OP_LW     = 6'h23;
    localparam logic [5:0] OP_LBU    = 6'h24;
    localparam logic [5:0] OP_LHU    = 6'h25;
    localparam logic [5:0] OP_SB     = 6'h28;
    localparam logic [5:0] OP_SH     = 6'h29;
    localparam logic [5:0] OP_SW     = 6'h2b;
    localparam logic [5:0] OP_BUBBLE = 6'h15;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } size_t;

    state_t      state;
    logic [31:0] store_q;
    logic        reg_we_q;
    logic        mem_re_q;
    logic        mem_we_q;
    logic [31:0] mem_dout_q;

    logic        in_access;
    logic        load_done;
    logic        next_mis;
    logic        cur_mis;
    size_t       size;
    logic [31:0] load_data;
    logic [7:0]  load_byte;
    logic [15:0] load_half;

`ifdef MEM_MISALIGN_TRAP_EN
    function automatic logic is_misaligned(input logic [5:0] op, input logic [1:0] lo);
        case (op)
            OP_LH, OP_LHU, OP_SH: is_misaligned = lo[0];
            OP_LW, OP_SW:         is_misaligned = (lo != 2'b00);
            default:              is_misaligned = 1'b0;
        endcase
    endfunction

    assign next_mis = (NextMemRE | NextMemWE) & is_misaligned(NextOpcode, NextALUOut[1:0]);
    assign cur_mis  = (mem_re_q | mem_we_q) & is_misaligned(Opcode, ALUOut[1:0]);
`else
    assign next_mis = 1'b0;
    assign cur_mis  = 1'b0;
`endif

    assign in_access = (state == ACCESS);
    assign MemStall  = in_access & ~dmem.DMemAck;
    assign load_done = in_access & dmem.DMemAck & mem_re_q;

    // Pipeline register and access FSM. Nothing advances while MemStall is
    // high; the ack edge of an access is also the capture edge of the next
    // instruction, which lets back-to-back accesses keep DMemReq asserted.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            ALUOut     <= '0;
            FPUOut     <= '0;
            store_q    <= '0;
            Opcode     <= OP_BUBBLE;
            Funct      <= '0;
            PCPlusFour <= '0;
            Immediate  <= '0;
            DInSrc     <= '0;
            reg_we_q   <= 1'b0;
            RegWAddr   <= '0;
            mem_re_q   <= 1'b0;
            mem_we_q   <= 1'b0;
            mem_dout_q <= '0;
        end else begin
            if (load_done) begin
                mem_dout_q <= load_data;
            end
            if (!MemStall) begin
                if (stall) begin
                    state      <= IDLE;
                    ALUOut     <= '0;
                    FPUOut     <= '0;
                    store_q    <= '0;
                    Opcode     <= OP_BUBBLE;
                    Funct      <= '0;
                    PCPlusFour <= '0;
                    Immediate  <= '0;
                    DInSrc     <= '0;
                    reg_we_q   <= 1'b0;
                    RegWAddr   <= '0;
                    mem_re_q   <= 1'b0;
                    mem_we_q   <= 1'b0;
                end else begin
                    state      <= ((NextMemRE | NextMemWE) & ~next_mis) ? ACCESS : IDLE;
                    ALUOut     <= NextALUOut;
                    FPUOut     <= NextFPUOut;
                    store_q    <= NextStoreData;
                    Opcode     <= NextOpcode;
                    Funct      <= NextFunct;
                    PCPlusFour <= NextPCPlusFour;
                    Immediate  <= NextImmediate;
                    DInSrc     <= NextDInSrc;
                    reg_we_q   <= NextRegWE;
                    RegWAddr   <= NextRegWAddr;
                    mem_re_q   <= NextMemRE;
                    mem_we_q   <= NextMemWE;
                end
            end
        end
    end

    // Unknown opcodes with a memory flag are treated as word accesses.
    always_comb begin
        size = SZ_WORD;
        case (Opcode)
            OP_LB, OP_LBU, OP_SB: size = SZ_BYTE;
            OP_LH, OP_LHU, OP_SH: size = SZ_HALF;
            default:              size = SZ_WORD;
        endcase
    end

    // Bus drive: everything below depends only on registered state, so it is
    // stable for the whole request.
    always_comb begin
        dmem.DMemByteEn = 4'b1111;
        dmem.DMemWData  = store_q;
        case (size)
            SZ_BYTE: begin
                dmem.DMemByteEn = 4'b1000 >> ALUOut[1:0];
                dmem.DMemWData  = {4{store_q[7:0]}};
            end
            SZ_HALF: begin
                dmem.DMemByteEn = ALUOut[1] ? 4'b0011 : 4'b1100;
                dmem.DMemWData  = {2{store_q[15:0]}};
            end
            default: begin
                dmem.DMemByteEn = 4'b1111;
                dmem.DMemWData  = store_q;
            end
        endcase
    end

    assign dmem.DMemAddr = {ALUOut[31:2], 2'b00};
    assign dmem.DMemReq  = in_access;
    assign dmem.DMemWE   = in_access & mem_we_q;

    // Load alignment: lane 0 is the most significant byte.
    always_comb begin
        load_byte = 8'h00;
        case (ALUOut[1:0])
            2'd0:    load_byte = dmem.DMemRData[31:24];
            2'd1:    load_byte = dmem.DMemRData[23:16];
            2'd2:    load_byte = dmem.DMemRData[15:8];
            default: load_byte = dmem.DMemRData[7:0];
        endcase
        load_half = ALUOut[1] ? dmem.DMemRData[15:0] : dmem.DMemRData[31:16];

        load_data = dmem.DMemRData;
        case (Opcode)
            OP_LB:   load_data = {{24{load_byte[7]}}, load_byte};
            OP_LBU:  load_data = {24'h000000, load_byte};
            OP_LH:   load_data = {{16{load_half[15]}}, load_half};
            OP_LHU:  load_data = {16'h0000, load_half};
            default: load_data = dmem.DMemRData;
        endcase
    end

    // Load data is forwarded combinationally in the ack cycle, then held.
    assign MEMDout = load_done ? load_data : mem_dout_q;

    assign RegWE         = reg_we_q & ~MemStall & ~cur_mis;
    assign MisalignedExc = cur_mis;
    assign dbg_state     = (state == ACCESS);

endmodule

// File: tb/tb_mem_access.sv
module tb_mem_access;

  logic        clk;
  logic        reset;
  logic        stall;
  logic [31:0] NextALUOut;
  logic [31:0] NextFPUOut;
  logic [31:0] NextStoreData;
  logic [5:0]  NextOpcode;
  logic [5:0]  NextFunct;
  logic [31:0] NextPCPlusFour;
  logic [15:0] NextImmediate;
  logic [1:0]  NextDInSrc;
  logic        NextRegWE;
  logic [5:0]  NextRegWAddr;
  logic        NextMemRE;
  logic        NextMemWE;
  logic [31:0] MEMDout;
  logic [31:0] ALUOut;
  logic [31:0] FPUOut;
  logic [31:0] PCPlusFour;
  logic [5:0]  Opcode;
  logic [5:0]  Funct;
  logic [15:0] Immediate;
  logic [1:0]  DInSrc;
  logic        RegWE;
  logic [5:0]  RegWAddr;
  logic        MemStall;
  logic        MisalignedExc;
  logic        dbg_state;

  mem_access_if dmem_bus ();

  mem_access dut (
    .clk            (clk),
    .reset          (reset),
    .stall          (stall),
    .NextALUOut     (NextALUOut),
    .NextFPUOut     (NextFPUOut),
    .NextStoreData  (NextStoreData),
    .NextOpcode     (NextOpcode),
    .NextFunct      (NextFunct),
    .NextPCPlusFour (NextPCPlusFour),
    .NextImmediate  (NextImmediate),
    .NextDInSrc     (NextDInSrc),
    .NextRegWE      (NextRegWE),
    .NextRegWAddr   (NextRegWAddr),
    .NextMemRE      (NextMemRE),
    .NextMemWE      (NextMemWE),
    .dmem           (dmem_bus),
    .MEMDout        (MEMDout),
    .ALUOut         (ALUOut),
    .FPUOut         (FPUOut),
    .PCPlusFour     (PCPlusFour),
    .Opcode         (Opcode),
    .Funct          (Funct),
    .Immediate      (Immediate),
    .DInSrc         (DInSrc),
    .RegWE          (RegWE),
    .RegWAddr       (RegWAddr),
    .MemStall       (MemStall),
    .MisalignedExc  (MisalignedExc),
    .dbg_state      (dbg_state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  // driver tasks
  task automatic drive_instr(input logic [5:0] op, input logic [31:0] addr,
                             input logic [31:0] sdata, input logic re,
                             input logic we, input logic rwe);
    stall          = 1'b0;
    NextOpcode     = op;
    NextALUOut     = addr;
    NextStoreData  = sdata;
    NextMemRE      = re;
    NextMemWE      = we;
    NextRegWE      = rwe;
    NextFunct      = 6'h00;
    NextFPUOut     = 32'hF00D_0001;
    NextPCPlusFour = 32'h0000_1004;
    NextImmediate  = 16'h0055;
    NextDInSrc     = 2'd1;
    NextRegWAddr   = 6'd5;
  endtask

  task automatic drive_bubble();
    stall          = 1'b1;
    NextOpcode     = 6'h00;
    NextALUOut     = '0;
    NextStoreData  = '0;
    NextMemRE      = 1'b0;
    NextMemWE      = 1'b0;
    NextRegWE      = 1'b0;
    NextFunct      = 6'h00;
    NextFPUOut     = '0;
    NextPCPlusFour = '0;
    NextImmediate  = '0;
    NextDInSrc     = '0;
    NextRegWAddr   = '0;
  endtask

  typedef struct packed {
    logic [5:0]  op;
    logic [31:0] addr;
    logic [31:0] sdata;
    logic [31:0] rdata;
    logic [3:0]  waits;
    logic        is_load;
    logic [31:0] exp_dout;
    logic [31:0] exp_wdata;
    logic [31:0] exp_addr;
    logic [3:0]  exp_be;
  } vec_t;

  localparam int NV = 9;
  vec_t vecs [NV];

  // Applies one access vector: capture, wait states, ack, then bubble.
  // Entered and left at a falling edge.
  task automatic run_vec(input int i);
    vec_t v;
    v = vecs[i];
    drive_instr(v.op, v.addr, v.sdata, v.is_load, ~v.is_load, v.is_load);
    @(posedge clk); #1;
    drive_bubble();
    for (int w = 0; w <= int'(v.waits); w++) begin
      dmem_bus.DMemAck   = (w == int'(v.waits));
      dmem_bus.DMemRData = v.rdata;
      @(negedge clk);
      check($sformatf("v%0d_c%0d_req", i, w), {31'b0, dmem_bus.DMemReq}, 32'd1);
      check($sformatf("v%0d_c%0d_stall", i, w), {31'b0, MemStall}, {31'b0, (w != int'(v.waits))});
      check($sformatf("v%0d_c%0d_regwe", i, w), {31'b0, RegWE},
            {31'b0, (w == int'(v.waits)) & v.is_load});
      check($sformatf("v%0d_c%0d_we", i, w), {31'b0, dmem_bus.DMemWE}, {31'b0, ~v.is_load});
      check($sformatf("v%0d_c%0d_addr", i, w), dmem_bus.DMemAddr, v.exp_addr);
      check($sformatf("v%0d_c%0d_be", i, w), {28'b0, dmem_bus.DMemByteEn}, {28'b0, v.exp_be});
      check($sformatf("v%0d_c%0d_op", i, w), {26'b0, Opcode}, {26'b0, v.op});
      if (!v.is_load)
        check($sformatf("v%0d_c%0d_wdata", i, w), dmem_bus.DMemWData, v.exp_wdata);
      if (v.is_load && w == int'(v.waits))
        check($sformatf("v%0d_dout_ack", i), MEMDout, v.exp_dout);
      @(posedge clk); #1;
    end
    dmem_bus.DMemAck   = 1'b0;
    dmem_bus.DMemRData = 32'h5A5A_5A5A;
    @(negedge clk);
    check($sformatf("v%0d_after_req", i), {31'b0, dmem_bus.DMemReq}, 32'd0);
    check($sformatf("v%0d_after_regwe", i), {31'b0, RegWE}, 32'd0);
    check($sformatf("v%0d_after_op", i), {26'b0, Opcode}, 32'h15);
    if (v.is_load)
      check($sformatf("v%0d_dout_held", i), MEMDout, v.exp_dout);
  endtask

  initial begin
    // vector table: op, addr, sdata, rdata, waits, is_load, dout, wdata, addr, be
    vecs[0] = '{6'h23, 32'h100, 32'h0, 32'hDEADBEEF, 4'd2, 1'b1, 32'hDEADBEEF, 32'h0, 32'h100, 4'b1111};
    vecs[1] = '{6'h20, 32'h103, 32'h0, 32'h000000F0, 4'd0, 1'b1, 32'hFFFFFFF0, 32'h0, 32'h100, 4'b0001};
    vecs[2] = '{6'h24, 32'h103, 32'h0, 32'h000000F0, 4'd1, 1'b1, 32'h000000F0, 32'h0, 32'h100, 4'b0001};
    vecs[3] = '{6'h21, 32'h102, 32'h0, 32'h12348765, 4'd0, 1'b1, 32'hFFFF8765, 32'h0, 32'h100, 4'b0011};
    vecs[4] = '{6'h25, 32'h100, 32'h0, 32'h9ABC1234, 4'd3, 1'b1, 32'h00009ABC, 32'h0, 32'h100, 4'b1100};
    vecs[5] = '{6'h20, 32'h101, 32'h0, 32'h117F2233, 4'd0, 1'b1, 32'h0000007F, 32'h0, 32'h100, 4'b0100};
    vecs[6] = '{6'h29, 32'h202, 32'h0000ABCD, 32'h0, 4'd0, 1'b0, 32'h0, 32'hABCDABCD, 32'h200, 4'b0011};
    vecs[7] = '{6'h28, 32'h305, 32'h123456A5, 32'h0, 4'd1, 1'b0, 32'h0, 32'hA5A5A5A5, 32'h304, 4'b0100};
    vecs[8] = '{6'h2b, 32'h40C, 32'hCAFEF00D, 32'h0, 4'd2, 1'b0, 32'h0, 32'hCAFEF00D, 32'h40C, 4'b1111};

    reset = 1'b0;
    dmem_bus.DMemAck   = 1'b0;
    dmem_bus.DMemRData = '0;
    drive_bubble();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // reset state
    check("rst_op", {26'b0, Opcode}, 32'h15);
    check("rst_regwe", {31'b0, RegWE}, 32'd0);
    check("rst_req", {31'b0, dmem_bus.DMemReq}, 32'd0);
    check("rst_stall", {31'b0, MemStall}, 32'd0);
    check("rst_mis", {31'b0, MisalignedExc}, 32'd0);
    check("rst_alu", ALUOut, 32'd0);

    // non-memory instruction, then a bubble
    drive_instr(6'h00, 32'h55, 32'h0, 1'b0, 1'b0, 1'b1);
    NextFunct = 6'h20;
    @(posedge clk); #1;
    drive_bubble();
    @(negedge clk);
    check("add_alu", ALUOut, 32'h55);
    check("add_regwe", {31'b0, RegWE}, 32'd1);
    check("add_stall", {31'b0, MemStall}, 32'd0);
    check("add_req", {31'b0, dmem_bus.DMemReq}, 32'd0);
    check("add_fpu", FPUOut, 32'hF00D0001);
    check("add_pc4", PCPlusFour, 32'h1004);
    check("add_imm", {16'b0, Immediate}, 32'h55);
    check("add_dinsrc", {30'b0, DInSrc}, 32'd1);
    check("add_waddr", {26'b0, RegWAddr}, 32'd5);
    check("add_funct", {26'b0, Funct}, 32'h20);
    @(negedge clk);
    check("bub_regwe", {31'b0, RegWE}, 32'd0);
    check("bub_op", {26'b0, Opcode}, 32'h15);
    check("bub_alu", ALUOut, 32'd0);
    check("bub_waddr", {26'b0, RegWAddr}, 32'd0);

    // table-driven loads and stores
    for (int i = 0; i < NV; i++) run_vec(i);

    // back-to-back loads: DMemReq stays high across the ack edge
    drive_instr(6'h23, 32'h10, 32'h0, 1'b1, 1'b0, 1'b1);
    @(posedge clk); #1;
    drive_instr(6'h23, 32'h20, 32'h0, 1'b1, 1'b0, 1'b1);
    dmem_bus.DMemAck = 1'b0;
    @(negedge clk);
    check("b2b_first_stall", {31'b0, MemStall}, 32'd1);
    check("b2b_first_regwe", {31'b0, RegWE}, 32'd0);
    @(posedge clk); #1;
    dmem_bus.DMemAck   = 1'b1;
    dmem_bus.DMemRData = 32'hAAAA5555;
    @(negedge clk);
    check("b2b_first_dout", MEMDout, 32'hAAAA5555);
    check("b2b_first_ack_stall", {31'b0, MemStall}, 32'd0);
    @(posedge clk); #1;
    drive_bubble();
    dmem_bus.DMemRData = 32'h0BADF00D;
    @(negedge clk);
    check("b2b_second_req", {31'b0, dmem_bus.DMemReq}, 32'd1);
    check("b2b_second_addr", dmem_bus.DMemAddr, 32'h20);
    check("b2b_second_dout", MEMDout, 32'h0BADF00D);
    check("b2b_second_regwe", {31'b0, RegWE}, 32'd1);
    @(posedge clk); #1;
    dmem_bus.DMemAck = 1'b0;
    @(negedge clk);
    check("b2b_end_req", {31'b0, dmem_bus.DMemReq}, 32'd0);

    // misaligned word load
    drive_instr(6'h23, 32'h102, 32'h0, 1'b1, 1'b0, 1'b1);
    @(posedge clk); #1;
    drive_bubble();
`ifdef MEM_MISALIGN_TRAP_EN
    @(negedge clk);
    check("mis_exc", {31'b0, MisalignedExc}, 32'd1);
    check("mis_req", {31'b0, dmem_bus.DMemReq}, 32'd0);
    check("mis_regwe", {31'b0, RegWE}, 32'd0);
    check("mis_stall", {31'b0, MemStall}, 32'd0);
    @(negedge clk);
    check("mis_exc_clear", {31'b0, MisalignedExc}, 32'd0);
`else
    dmem_bus.DMemAck   = 1'b1;
    dmem_bus.DMemRData = 32'h01020304;
    @(negedge clk);
    check("mis_exc", {31'b0, MisalignedExc}, 32'd0);
    check("mis_req", {31'b0, dmem_bus.DMemReq}, 32'd1);
    check("mis_addr", dmem_bus.DMemAddr, 32'h100);
    check("mis_dout", MEMDout, 32'h01020304);
    check("mis_regwe", {31'b0, RegWE}, 32'd1);
    @(posedge clk); #1;
    dmem_bus.DMemAck = 1'b0;
    @(negedge clk);
`endif

    // reset in the middle of an access
    drive_instr(6'h23, 32'h500, 32'h0, 1'b1, 1'b0, 1'b1);
    @(posedge clk); #1;
    drive_bubble();
    #2;
    check("rstmid_req_before", {31'b0, dmem_bus.DMemReq}, 32'd1);
    reset = 1'b0;
    #1;
    check("rstmid_req", {31'b0, dmem_bus.DMemReq}, 32'd0);
    check("rstmid_stall", {31'b0, MemStall}, 32'd0);
    check("rstmid_op", {26'b0, Opcode}, 32'h15);
    check("rstmid_regwe", {31'b0, RegWE}, 32'd0);
    check("rstmid_dout", MEMDout, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("rstmid_after_req", {31'b0, dmem_bus.DMemReq}, 32'd0);

    // ack outside an access is ignored
    dmem_bus.DMemAck   = 1'b1;
    dmem_bus.DMemRData = 32'hFFFFFFFF;
    @(posedge clk); #1;
    @(negedge clk);
    check("idle_ack_stall", {31'b0, MemStall}, 32'd0);
    check("idle_ack_req", {31'b0, dmem_bus.DMemReq}, 32'd0);
    check("idle_ack_regwe", {31'b0, RegWE}, 32'd0);
    check("idle_ack_dout", MEMDout, 32'd0);
    dmem_bus.DMemAck = 1'b0;
    @(negedge clk);

    // final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
